// File: rtl/pwm_deadtime_gen.sv
// Half-bridge PWM modulator: complementary hs/ls gate commands with dead time.
// Period/duty/deadtime are double-buffered and applied only at a period wrap or while disabled.
module pwm_deadtime_gen #(
   parameter int CNT_W = 10,
   parameter int DT_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   input  logic [DT_W-1:0]  deadtime,
   input  logic             load,
   output logic             update_ack,
   output logic             cycle_start,
   output logic             hs,
   output logic             ls
);

   typedef enum logic [1:0] {IDLE = 2'd0, HS_ON = 2'd1, LS_ON = 2'd2, DEAD = 2'd3} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_a_q, period_a_d, duty_a_q, duty_a_d;
   logic [CNT_W-1:0] period_s_q, period_s_d, duty_s_q, duty_s_d;
   logic [DT_W-1:0]  dt_a_q, dt_a_d, dt_s_q, dt_s_d;
   logic [DT_W-1:0]  dtc_q, dtc_d;
   logic             pending_q, pending_d;
   logic             update_ack_q, update_ack_d;
   logic             cycle_start_q, cycle_start_d;
   logic             pwm_r_q, pwm_r_d;
   logic             target_q, target_d;
   logic             hs_q, hs_d, ls_q, ls_d;
   logic             wrap, apply;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         period_a_q    <= '0;
         duty_a_q      <= '0;
         dt_a_q        <= '0;
         period_s_q    <= '0;
         duty_s_q      <= '0;
         dt_s_q        <= '0;
         dtc_q         <= '0;
         pending_q     <= 1'b0;
         update_ack_q  <= 1'b0;
         cycle_start_q <= 1'b0;
         pwm_r_q       <= 1'b0;
         target_q      <= 1'b0;
         hs_q          <= 1'b0;
         ls_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         period_a_q    <= period_a_d;
         duty_a_q      <= duty_a_d;
         dt_a_q        <= dt_a_d;
         period_s_q    <= period_s_d;
         duty_s_q      <= duty_s_d;
         dt_s_q        <= dt_s_d;
         dtc_q         <= dtc_d;
         pending_q     <= pending_d;
         update_ack_q  <= update_ack_d;
         cycle_start_q <= cycle_start_d;
         pwm_r_q       <= pwm_r_d;
         target_q      <= target_d;
         hs_q          <= hs_d;
         ls_q          <= ls_d;
      end
   end

   // Counter, staging and apply. A load coinciding with an apply re-arms pending,
   // so its values wait for the following wrap.
   always_comb begin
      wrap          = (period_a_q < CNT_W'(2)) || (cnt_q == period_a_q - CNT_W'(1));
      apply         = pending_q && (!en || wrap);
      cnt_d         = (!en || wrap) ? '0 : cnt_q + CNT_W'(1);
      cycle_start_d = en && (cnt_q == '0);
      pwm_r_d       = en && (cnt_q < duty_a_q);
      update_ack_d  = apply;
      period_a_d    = apply ? period_s_q : period_a_q;
      duty_a_d      = apply ? duty_s_q   : duty_a_q;
      dt_a_d        = apply ? dt_s_q     : dt_a_q;
      period_s_d    = load ? period   : period_s_q;
      duty_s_d      = load ? duty     : duty_s_q;
      dt_s_d        = load ? deadtime : dt_s_q;
      pending_d     = load ? 1'b1 : (apply ? 1'b0 : pending_q);
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dtc_d    = dtc_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = DEAD;
               target_d = pwm_r_q;
               dtc_d    = dt_a_q;
            end
            HS_ON: if (!pwm_r_q) begin
               state_d  = DEAD;
               target_d = 1'b0;
               dtc_d    = dt_a_q;
            end
            LS_ON: if (pwm_r_q) begin
               state_d  = DEAD;
               target_d = 1'b1;
               dtc_d    = dt_a_q;
            end
            DEAD: begin
               // dtc is captured on entry only, so an update never shortens a dead gap
               target_d = pwm_r_q;
               if (dtc_q == '0) state_d = target_q ? HS_ON : LS_ON;
               else             dtc_d   = dtc_q - DT_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
      hs_d = (state_d == HS_ON);
      ls_d = (state_d == LS_ON);
   end

   assign update_ack  = update_ack_q;
   assign cycle_start = cycle_start_q;
   assign hs          = hs_q;
   assign ls          = ls_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: a timestamp-based reference model pushes the
// expected outputs after each edge; a monitor pops and compares on the falling edge.
module tb_pwm_deadtime_gen;

   localparam int CNT_W = 10;
   localparam int DT_W  = 6;

   logic             clk;
   logic             rst;
   logic             en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] duty;
   logic [DT_W-1:0]  deadtime;
   logic             load;
   logic             update_ack, cycle_start, hs, ls;

   pwm_deadtime_gen #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
      .deadtime(deadtime), .load(load), .update_ack(update_ack),
      .cycle_start(cycle_start), .hs(hs), .ls(ls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic hs;
      logic ls;
      logic ack;
      logic cs;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state (values visible in the current cycle)
   int m_cyc = 0;
   int m_cnt = 0, m_per = 0, m_duty = 0, m_dt = 0;
   int s_per = 0, s_duty = 0, s_dt = 0;
   bit m_pend = 0, m_pwm = 0, m_ack = 0, m_cs = 0;
   int m_side = 0;         // 0 none, 1 high side conducting, 2 low side conducting
   bit m_in_dead = 0;
   int m_dead_exit = 0;    // cycle index whose closing edge ends the dead gap
   bit m_tgt = 0;

   task automatic model_step();
      bit wrap, apply;
      int n_cnt;
      if (rst) begin
         m_cnt = 0; m_per = 0; m_duty = 0; m_dt = 0;
         s_per = 0; s_duty = 0; s_dt = 0;
         m_pend = 0; m_pwm = 0; m_ack = 0; m_cs = 0;
         m_side = 0; m_in_dead = 0; m_tgt = 0;
      end else begin
         wrap  = (m_per < 2) || (m_cnt == m_per - 1);
         apply = m_pend && (!en || wrap);
         n_cnt = (!en || wrap) ? 0 : m_cnt + 1;
         // Gate side uses the delayed pwm and the dead time active this cycle
         if (!en) begin
            m_side = 0; m_in_dead = 0;
         end else if (m_in_dead) begin
            if (m_cyc == m_dead_exit) begin
               m_side = m_tgt ? 1 : 2;
               m_in_dead = 0;
            end
            m_tgt = m_pwm;
         end else if (m_side == 0 || (m_side == 1 && !m_pwm) || (m_side == 2 && m_pwm)) begin
            m_side = 0; m_in_dead = 1;
            m_dead_exit = m_cyc + m_dt + 1;
            m_tgt = m_pwm;
         end
         m_ack = apply;
         m_cs  = en && (m_cnt == 0);
         m_pwm = en && (m_cnt < m_duty);
         m_cnt = n_cnt;
         if (apply) begin
            m_per = s_per; m_duty = s_duty; m_dt = s_dt;
         end
         if (load) begin
            s_per = int'(period); s_duty = int'(duty); s_dt = int'(deadtime);
         end
         m_pend = load ? 1'b1 : (apply ? 1'b0 : m_pend);
      end
      m_cyc++;
   endtask

   // One clock: evaluate the model on the inputs about to be sampled, then post its
   // expectation once the edge has happened.
   task automatic tick();
      exp_t e;
      model_step();
      e.hs  = (m_side == 1);
      e.ls  = (m_side == 2);
      e.ack = m_ack;
      e.cs  = m_cs;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input int p, input int d, input int dt);
      period = CNT_W'(p); duty = CNT_W'(d); deadtime = DT_W'(dt);
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_fail(input string what);
      total++;
      bad++;
      $display("FAIL wait_%s: condition not reached within cycle budget", what);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({hs, ls, update_ack, cycle_start} !== e) begin
            bad++;
            $display("FAIL outputs t=%0t got hs=%b ls=%b ack=%b cs=%b want hs=%b ls=%b ack=%b cs=%b",
                     $time, hs, ls, update_ack, cycle_start, e.hs, e.ls, e.ack, e.cs);
         end
         total++;
         if ((hs & ls) !== 1'b0) begin
            bad++;
            $display("FAIL overlap t=%0t got hs&ls=%b want 0", $time, hs & ls);
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1; en = 1'b0; load = 1'b0;
      period = '0; duty = '0; deadtime = '0;
      @(posedge clk);
      #1;
      ticks(3);
      rst = 1'b0;
      ticks(2);

      // Stage with the modulator off: applies on the next cycle
      do_load(10, 4, 2);
      ticks(4);

      // Steady state 10-cycle pattern
      en = 1'b1;
      ticks(45);

      // 0% then 100% duty with no dead time
      do_load(10, 0, 0);
      ticks(25);
      do_load(10, 10, 0);
      ticks(25);

      // Mid-period duty change at cnt==5
      do_load(10, 4, 2);
      ticks(25);
      for (k = 0; k < 50 && m_cnt != 5; k++) tick();
      if (m_cnt != 5) wait_fail("cnt5");
      do_load(10, 6, 2);
      ticks(25);

      // Load coinciding with a wrap
      for (k = 0; k < 50 && m_cnt != 9; k++) tick();
      if (m_cnt != 9) wait_fail("cnt9");
      do_load(10, 3, 1);
      ticks(25);

      // Reset pulse while in a dead gap, then restage and re-enable
      for (k = 0; k < 50 && !m_in_dead; k++) tick();
      if (!m_in_dead) wait_fail("dead");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b0;
      do_load(10, 5, 3);
      ticks(2);
      en = 1'b1;
      ticks(30);

      // Drop enable while high side conducts
      for (k = 0; k < 50 && m_side != 1; k++) tick();
      if (m_side != 1) wait_fail("hs");
      en = 1'b0;
      ticks(3);
      en = 1'b1;
      ticks(25);

      // Randomized traffic, biased to small periods so boundaries recur often
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) en = ~en;
         else if (!en && $urandom_range(0, 99) < 20) en = 1'b1;
         rst = ($urandom_range(0, 299) == 0);
         load = ($urandom_range(0, 99) < 4);
         period = CNT_W'($urandom_range(0, 16));
         duty = CNT_W'($urandom_range(0, 18));
         deadtime = DT_W'($urandom_range(0, 4));
         tick();
      end
      rst = 1'b0; load = 1'b0;
      ticks(2);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
